// File: rtl/rtl_settings_pkg.sv
// Shared types for the memory test sequencer.
// Test/address mode encodings, FSM states and op codes.
package rtl_settings_pkg;

    typedef enum logic [1:0] {
        WRITE_ONLY      = 2'd0,
        READ_ONLY       = 2'd1,
        WRITE_AND_CHECK = 2'd2
    } test_mode_t;

    typedef enum logic [2:0] {
        FIX_ADDR   = 3'd0,
        RND_ADDR   = 3'd1,
        RUN_0_ADDR = 3'd2,
        RUN_1_ADDR = 3'd3,
        INC_ADDR   = 3'd4,
        DEC_ADDR   = 3'd5
    } addr_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    localparam logic OP_WRITE = 1'b0;
    localparam logic OP_READ  = 1'b1;

endpackage

// File: rtl/mem_test_addr_gen.sv
// Address generator for the memory test sequencer.
// All address modes, the LFSR and a batch snapshot/restore slot.
module mem_test_addr_gen
    import rtl_settings_pkg::*;
#(
    parameter int ADDR_W = 26,
    parameter int LFSR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              init_i,
    input  logic              advance_i,
    input  logic              snapshot_i,
    input  logic              restore_i,
    input  addr_mode_t        mode_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] limit_i,
    input  logic [LFSR_W-1:0] seed_i,
    output logic [ADDR_W-1:0] addr_o
);

    // x^32+x^22+x^2+x+1 mapped onto an LFSR_W-bit Galois register
    localparam logic [LFSR_W-1:0] TAPS =
        (LFSR_W'(1) << (LFSR_W - 1)) |
        (LFSR_W'(1) << (LFSR_W - 11)) |
        LFSR_W'(3);

    addr_mode_t        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] limit_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] snap_addr_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] snap_lfsr_q;

    logic [ADDR_W-1:0] addr_nxt;
    logic [ADDR_W-1:0] addr_init;
    logic [LFSR_W-1:0] lfsr_nxt;
    logic [LFSR_W-1:0] seed_init;
    logic              win_ok;
    logic              win_in;

    // Next address, next LFSR value and start-of-test values
    always_comb begin
        win_ok   = (limit_q >= base_q);
        win_in   = (limit_i >= base_i);
        lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS)
                             : (lfsr_q >> 1);
        case (mode_q)
            RUN_0_ADDR, RUN_1_ADDR:
                addr_nxt = {addr_q[ADDR_W-2:0], addr_q[ADDR_W-1]};
            INC_ADDR:
                addr_nxt = (!win_ok || addr_q == limit_q) ? base_q
                         : addr_q + ADDR_W'(1);
            DEC_ADDR:
                addr_nxt = !win_ok ? base_q
                         : (addr_q == base_q) ? limit_q
                         : addr_q - ADDR_W'(1);
            default:
                addr_nxt = base_q;
        endcase
        case (mode_i)
            RUN_0_ADDR: addr_init = ~ADDR_W'(1);
            RUN_1_ADDR: addr_init = ADDR_W'(1);
            DEC_ADDR:   addr_init = win_in ? limit_i : base_i;
            default:    addr_init = base_i;
        endcase
        seed_init = (seed_i == '0) ? '1 : seed_i;
    end

    // Generator state: load on init, rewind on restore, step on advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q      <= FIX_ADDR;
            base_q      <= '0;
            limit_q     <= '0;
            addr_q      <= '0;
            snap_addr_q <= '0;
            lfsr_q      <= '1;
            snap_lfsr_q <= '1;
        end else if (init_i) begin
            mode_q      <= mode_i;
            base_q      <= base_i;
            limit_q     <= limit_i;
            addr_q      <= addr_init;
            snap_addr_q <= addr_init;
            lfsr_q      <= seed_init;
            snap_lfsr_q <= seed_init;
        end else begin
            if (restore_i) begin
                addr_q <= snap_addr_q;
                lfsr_q <= snap_lfsr_q;
            end else if (advance_i) begin
                addr_q <= addr_nxt;
                lfsr_q <= lfsr_nxt;
            end
            if (snapshot_i) begin
                snap_addr_q <= advance_i ? addr_nxt : addr_q;
                snap_lfsr_q <= advance_i ? lfsr_nxt : lfsr_q;
            end
        end
    end

    assign addr_o = (mode_q == RND_ADDR) ? lfsr_q[ADDR_W-1:0] : addr_q;

endmodule

// File: rtl/mem_test_sequencer.sv
// Memory test command sequencer.
// Issues write/read ops in batches, then drains downstream.
module mem_test_sequencer
    import rtl_settings_pkg::*;
#(
    parameter int ADDR_W    = 26,
    parameter int CNT_W     = 32,
    parameter int BATCH_W   = 4,
    parameter int LFSR_W    = 32,
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  test_mode_t           test_mode_i,
    input  addr_mode_t           addr_mode_i,
    input  logic [CNT_W-1:0]     test_count_i,
    input  logic [BATCH_W-1:0]   batch_size_i,
    input  logic [ADDR_W-1:0]    base_addr_i,
    input  logic [ADDR_W-1:0]    limit_addr_i,
    input  logic [LFSR_W-1:0]    lfsr_seed_i,
    input  logic                 stop_on_err_i,
    input  logic                 err_i,
    input  logic                 downstream_busy_i,
    input  logic                 op_ready_i,
    output logic                 op_valid_o,
    output logic                 op_type_o,
    output logic [ADDR_W-1:0]    op_addr_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    seq_state_t         state_q;
    test_mode_t         tmode_q;
    logic               stop_q;
    logic               abort_pend_q;
    logic [CNT_W-1:0]   rem_q;
    logic [BATCH_W-1:0] bsize_q;
    logic [BATCH_W-1:0] blen_q;
    logic [BATCH_W-1:0] bcnt_q;

    logic               fire;
    logic               abort_ev;
    logic               wac;
    logic               last_in_batch;
    logic               last_word;
    logic               ag_init;
    logic               ag_adv;
    logic               ag_snap;
    logic               ag_rest;
    logic [BATCH_W-1:0] bs_in;

    function automatic logic [BATCH_W-1:0] batch_len(
        input logic [CNT_W-1:0]   rem,
        input logic [BATCH_W-1:0] bs
    );
        batch_len = (rem < CNT_W'(bs)) ? rem[BATCH_W-1:0] : bs;
    endfunction

    // Handshake, abort detection and address generator controls
    always_comb begin
        fire          = op_valid_o & op_ready_i;
        abort_ev      = (state_q != ST_IDLE)
                      & (abort_i | (err_i & stop_q));
        wac           = (tmode_q == WRITE_AND_CHECK);
        last_in_batch = (bcnt_q == blen_q - BATCH_W'(1));
        last_word     = (rem_q == CNT_W'(1));
        bs_in         = (batch_size_i == '0) ? BATCH_W'(1)
                                             : batch_size_i;
        ag_init       = (state_q == ST_IDLE) & start_i;
        ag_rest       = fire & wac & last_in_batch
                      & (state_q == ST_WRITE);
        ag_adv        = fire & ~ag_rest;
        ag_snap       = fire & wac & last_in_batch
                      & (state_q == ST_READ);
    end

    mem_test_addr_gen #(
        .ADDR_W (ADDR_W),
        .LFSR_W (LFSR_W)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .init_i     (ag_init),
        .advance_i  (ag_adv),
        .snapshot_i (ag_snap),
        .restore_i  (ag_rest),
        .mode_i     (addr_mode_i),
        .base_i     (base_addr_i),
        .limit_i    (limit_addr_i),
        .seed_i     (lfsr_seed_i),
        .addr_o     (op_addr_o)
    );

    assign op_type_o = (state_q == ST_READ) ? OP_READ : OP_WRITE;

    // Test FSM with counters, error policy and registered status
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tmode_q      <= WRITE_ONLY;
            stop_q       <= 1'b0;
            abort_pend_q <= 1'b0;
            rem_q        <= '0;
            bsize_q      <= '0;
            blen_q       <= '0;
            bcnt_q       <= '0;
            op_valid_o   <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            fail_o       <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            done_o <= 1'b0;
            if (state_q != ST_IDLE && err_i) begin
                fail_o <= 1'b1;
                if (err_cnt_o != {ERR_CNT_W{1'b1}})
                    err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
            end
            if (abort_ev)
                fail_o <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        fail_o       <= 1'b0;
                        err_cnt_o    <= '0;
                        busy_o       <= 1'b1;
                        tmode_q      <= test_mode_i;
                        stop_q       <= stop_on_err_i;
                        abort_pend_q <= 1'b0;
                        rem_q        <= test_count_i;
                        bsize_q      <= bs_in;
                        blen_q       <= batch_len(test_count_i, bs_in);
                        bcnt_q       <= '0;
                        if (test_count_i == '0) begin
                            state_q    <= ST_DRAIN;
                            op_valid_o <= 1'b0;
                        end else begin
                            state_q    <= (test_mode_i == READ_ONLY)
                                        ? ST_READ : ST_WRITE;
                            op_valid_o <= 1'b1;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (abort_ev || abort_pend_q) begin
                        if (fire) begin
                            op_valid_o   <= 1'b0;
                            abort_pend_q <= 1'b0;
                            state_q      <= ST_DRAIN;
                        end else begin
                            abort_pend_q <= 1'b1;
                        end
                    end else if (fire) begin
                        if (!wac) begin
                            rem_q <= rem_q - CNT_W'(1);
                            if (last_word) begin
                                op_valid_o <= 1'b0;
                                state_q    <= ST_DRAIN;
                            end
                        end else if (state_q == ST_WRITE) begin
                            if (last_in_batch) begin
                                bcnt_q  <= '0;
                                state_q <= ST_READ;
                            end else begin
                                bcnt_q <= bcnt_q + BATCH_W'(1);
                            end
                        end else begin
                            rem_q <= rem_q - CNT_W'(1);
                            if (last_in_batch) begin
                                bcnt_q <= '0;
                                if (last_word) begin
                                    op_valid_o <= 1'b0;
                                    state_q    <= ST_DRAIN;
                                end else begin
                                    state_q <= ST_WRITE;
                                    blen_q  <= batch_len(
                                        rem_q - CNT_W'(1), bsize_q);
                                end
                            end else begin
                                bcnt_q <= bcnt_q + BATCH_W'(1);
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!downstream_busy_i) begin
                        state_q <= ST_DONE;
                        done_o  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_test_sequencer.md
Name: mem_test_sequencer

Overview:
- Next-generation test command sequencer for the memory checker; replaces the fixed single-word write/read control path.
- Adds configurable write-then-read batching, a parametrised LFSR, and a bounded incrementing/decrementing address window.
- Adds abort, an error policy and a saturating error counter.
- Sits between the CSR block and the transaction block, issuing one op per valid/ready handshake, then waiting for downstream blocks to drain.

Parameters:
- ADDR_W, 26, word-address width.
- CNT_W, 32, test word-count width.
- BATCH_W, 4, batch-size field width; max batch = 2**BATCH_W-1.
- LFSR_W, 32, random-address LFSR width; must be >= ADDR_W.
- ERR_CNT_W, 16, error counter width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  one-cycle start pulse; ignored unless busy_o=0
- abort_i  in  1  one-cycle abort request
- test_mode_i  in  test_mode_t  WRITE_ONLY / READ_ONLY / WRITE_AND_CHECK
- addr_mode_i  in  addr_mode_t  FIX / RND / RUN_0 / RUN_1 / INC / DEC
- test_count_i  in  CNT_W  number of words to test
- batch_size_i  in  BATCH_W  words per write/read batch (0 treated as 1)
- base_addr_i  in  ADDR_W  fixed address / window base / INC-DEC start
- limit_addr_i  in  ADDR_W  window top, inclusive
- lfsr_seed_i  in  LFSR_W  RND seed; 0 is replaced by all-ones
- stop_on_err_i  in  1  1: error aborts the test
- err_i  in  1  compare-block mismatch pulse
- downstream_busy_i  in  1  OR of compare/measure/transaction busy
- op_ready_i  in  1  transaction block accepts op
- op_valid_o  out  1  op valid
- op_type_o  out  1  0=write, 1=read
- op_addr_o  out  ADDR_W  op word address
- busy_o  out  1  test in progress
- done_o  out  1  one-cycle pulse at test end
- fail_o  out  1  sticky: error seen or aborted; cleared on start
- err_cnt_o  out  ERR_CNT_W  saturating error count; cleared on start

Behaviour:
- Reset: state IDLE. op_valid_o, busy_o, done_o, fail_o = 0. err_cnt_o = 0. LFSR all-ones. Address and counter registers don't-care.
- Configuration inputs are sampled on an accepted start_i and held internally; changes during a test have no effect.
- Handshake: an op transfers when op_valid_o & op_ready_i. op_type_o and op_addr_o are stable while valid is high and not yet accepted. Valid is never withdrawn without acceptance, including on abort.
- With op_ready_i held high, back-to-back ops issue every cycle. First op_valid_o appears the cycle after start_i.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE -> start_i:
  - test_count_i = 0: go to DRAIN.
  - READ_ONLY: go to READ.
  - Otherwise: go to WRITE.
- WRITE_ONLY / READ_ONLY: one op per word; after the last accepted op, go to DRAIN.
- WRITE_AND_CHECK:
  - Batch length B = min(batch_size, remaining).
  - At batch start, snapshot the address generator. Write B words, restore the snapshot, then read the same B addresses in the same order.
  - Remaining count decrements on each accepted read. When remaining = 0 go to DRAIN, else go to WRITE.
- Address generator advances on each accepted op; the first op uses the initial address.
  - FIX: base_addr every op.
  - RND: Galois LFSR, polynomial x^32+x^22+x^2+x+1, scaled to LFSR_W. Address = LFSR[ADDR_W-1:0].
  - RUN_0: walking zero; initial value has bit0=0, all other bits 1; rotate left.
  - RUN_1: walking one; initial value 1; rotate left.
  - INC: start at base, +1, wrap from limit to base.
  - DEC: start at limit, -1, wrap from base to limit.
  - If limit < base, INC/DEC behave as FIX(base).
- Abort (abort_i, or err_i with stop_on_err_i):
  - Set fail_o.
  - Finish any pending valid op, issue no further ops, go to DRAIN.
  - Ignored in IDLE.
- err_i: increments err_cnt_o (saturating at all-ones) and sets fail_o in any state except IDLE.
  - err_i in IDLE is ignored.
  - Simultaneous start_i and err_i: the clear wins.
- DRAIN: wait for downstream_busy_i=0 (at least one cycle in DRAIN), then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in all states except IDLE.
- Counters are CNT_W wide; the maximum test_count_i must not overflow.

Decomposition:
- Package rtl_settings_pkg gets test_mode_t and addr_mode_t (extended with DEC_ADDR), plus OP_WRITE/OP_READ constants.
- Sub-module mem_test_addr_gen:
  - Holds all address modes and the LFSR.
  - Inputs: init, advance, snapshot, restore.
  - Output: current address.
- The sequencer keeps the FSM, counters and handshake.

Test Plan:
- WRITE_AND_CHECK, INC, base=0x10, limit=0x12, count=5, batch=2, ready=1 -> ops W10 W11 R10 R11 W12 W10 R12 R10 W11 R11; done_o one cycle after busy drops.
- READ_ONLY, RND, seed=0, count=3 -> LFSR starts all-ones; 3 reads at successive LFSR values; fail_o=0.
- WRITE_ONLY, RUN_1, ADDR_W=26, count=27, ready toggling 1/0 -> addresses 1,2,4..2^25,1; payload held stable while ready=0.
- count=0 -> no op_valid_o; done_o within 3 cycles of start once busy is low; fail_o=0.
- stop_on_err=1, err_i during the 2nd read while op pending -> pending op completes, no further ops, fail_o=1, err_cnt_o=1, done_o after downstream_busy_i falls.
- stop_on_err=0, 70000 err_i pulses with ERR_CNT_W=16 -> err_cnt_o saturates at 0xFFFF; test runs to completion; next start clears fail_o and err_cnt_o.
